// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register-file writer side.
// Used by reg_writeback, its FIFO, the register file and the issue stage.
//   XLEN       : result / register width
//   REG_ADDR_W : register index width (32 architectural registers)
//   X0         : hard-wired zero register index
//   wb_entry_t : one pending register-file write {rd, data}
package reg_writeback_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// wb_fifo: DEPTH-entry in-order FIFO of pending register-file writes.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   push, push_entry        : write push_entry at the tail (ignored when full)
//   pop                     : retire the head entry (ignored when empty)
//   head_entry              : current head, combinational from storage
//   full, empty, count      : occupancy status, count = 0..DEPTH
//   entry_valid, entry_rd   : per-slot valid flag and destination, for
//                             pending-write lookups by the owner
import reg_writeback_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    output wb_entry_t                 head_entry,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          entry_valid,
    output logic [REG_ADDR_W-1:0]     entry_rd [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_entry = mem[head];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i] = mem[i].rd;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. Push and pop
    // never target the same slot: that only happens when empty (no pop) or
    // full (no push).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[tail]         <= push_entry;
                entry_valid[tail] <= 1'b1;
                tail              <= tail + PTR_W'(1);
            end
            if (pop_ok) begin
                entry_valid[head] <= 1'b0;
                head              <= head + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: collects load and ALU results and issues register-file
// writes in acceptance order, one per cycle.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   ld_valid/ld_ready/ld_rd/ld_data   : load result handshake (priority)
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//   wb_stall                          : register-file port busy, hold head
//   reg_write/rd/write_data           : register-file write port
//   chk_rs1/chk_rs2                   : issue-stage source registers
//   rs1_pending/rs2_pending           : a queued write targets that source
//   count                             : queued writes, 0..DEPTH
import reg_writeback_pkg::*;

module reg_writeback #(
    parameter int XLEN  = reg_writeback_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [4:0]              ld_rd,
    input  logic [XLEN-1:0]         ld_data,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [4:0]              alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    input  logic                    wb_stall,
    output logic                    reg_write,
    output logic [4:0]              rd,
    output logic [XLEN-1:0]         write_data,
    input  logic [4:0]              chk_rs1,
    input  logic [4:0]              chk_rs2,
    output logic                    rs1_pending,
    output logic                    rs2_pending,
    output logic [$clog2(DEPTH):0]  count
);

    logic                  full;
    logic                  empty;
    logic                  ld_accept;
    logic                  alu_accept;
    logic                  push;
    wb_entry_t             push_entry;
    wb_entry_t             head_entry;
    logic [DEPTH-1:0]      entry_valid;
    logic [REG_ADDR_W-1:0] entry_rd [DEPTH];

    // Readies are forced low while reset is held so no producer sees a
    // handshake that the cleared FIFO would then drop.
    assign ld_ready  = reset_n && !full;
    assign alu_ready = reset_n && !full && !ld_valid;

    assign ld_accept  = ld_valid && ld_ready;
    assign alu_accept = alu_valid && alu_ready;

    // Results for x0 complete their handshake but are never queued.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (ld_accept) begin
            push       = (ld_rd != X0);
            push_entry = '{rd: ld_rd, data: ld_data};
        end else if (alu_accept) begin
            push       = (alu_rd != X0);
            push_entry = '{rd: alu_rd, data: alu_data};
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (reg_write),
        .head_entry  (head_entry),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    assign reg_write  = !empty && !wb_stall;
    assign rd         = head_entry.rd;
    assign write_data = head_entry.data;

    // Only stored entries are compared; a result accepted this cycle shows
    // up as pending from the next cycle on.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_rd[i] == chk_rs1) && (chk_rs1 != X0))
                rs1_pending = 1'b1;
            if (entry_valid[i] && (entry_rd[i] == chk_rs2) && (chk_rs2 != X0))
                rs2_pending = 1'b1;
        end
    end

endmodule
